// File: rtl/branch_sequencer_pkg.sv
// branch_sequencer_pkg: state encoding and branch condition codes
package branch_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7
    } state_e;

    // IR[20:19] condition codes; the CON flip-flop evaluates these
    typedef enum logic [1:0] {
        COND_ZR = 2'b00,
        COND_NZ = 2'b01,
        COND_PL = 2'b10,
        COND_MI = 2'b11
    } cond_e;

endpackage

// File: rtl/branch_sequencer_sat_counter.sv
// sat_counter: statistics counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // count up on inc until every bit is set
    always_ff @(posedge Clock) begin
        if (!clear) count_q <= '0;
        else if (inc && !(&count_q)) count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign count = count_q;

endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: conditional-branch control sequence with taken/issued statistics
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             start,
    input  logic             mem_done,
    input  logic             CON,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             Zlowout,
    output logic             PCin,
    output logic             Read,
    output logic             Mdatain,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Gra,
    output logic             Rout,
    output logic             CONin,
    output logic             Yin,
    output logic             Cout,
    output logic             ADD,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    state_e state_q, state_d;
    logic   taken_q, taken_d;
    logic   fin;

    // state and last-branch outcome registers
    always_ff @(posedge Clock) begin
        if (!clear) begin
            state_q <= IDLE;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
        end
    end

    // next-state logic and Moore strobe decode; T6 also gates PCin with CON
    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        fin     = 1'b0;
        PCout   = 1'b0;
        MARin   = 1'b0;
        IncPC   = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        PCin    = 1'b0;
        Read    = 1'b0;
        Mdatain = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Gra     = 1'b0;
        Rout    = 1'b0;
        CONin   = 1'b0;
        Yin     = 1'b0;
        Cout    = 1'b0;
        ADD     = 1'b0;
        case (state_q)
            IDLE: state_d = start ? T0 : IDLE;
            T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = T1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                Mdatain = 1'b1;
                MDRin   = 1'b1;
                state_d = mem_done ? T2 : T1;
            end
            T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = T3;
            end
            T3: begin
                Gra     = 1'b1;
                Rout    = 1'b1;
                CONin   = 1'b1;
                state_d = T4;
            end
            T4: begin
                PCout   = 1'b1;
                Yin     = 1'b1;
                state_d = T5;
            end
            T5: begin
                Cout    = 1'b1;
                ADD     = 1'b1;
                Zin     = 1'b1;
                state_d = T6;
            end
            T6: begin
                Zlowout = 1'b1;
                PCin    = CON;
                fin     = 1'b1;
                taken_d = CON;
                state_d = start ? T0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = state_q != IDLE;
    assign done  = fin;
    assign taken = taken_q;

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .Clock (Clock),
        .clear (clear),
        .inc   (fin),
        .count (branch_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .Clock (Clock),
        .clear (clear),
        .inc   (fin & CON),
        .count (taken_count)
    );

endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: randomized branch sequences checked against a phase-table reference model
module tb_branch_sequencer;
    import branch_sequencer_pkg::*;

    logic Clock = 1'b0;
    logic clear, start, mem_done, CON;
    logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Mdatain, MDRin, MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD;
    logic busy, done, taken;
    logic [15:0] branch_count, taken_count;
    logic PCout2, MARin2, IncPC2, Zin2, Zlowout2, PCin2, Read2, Mdatain2, MDRin2, MDRout2, IRin2, Gra2, Rout2, CONin2, Yin2, Cout2, ADD2;
    logic busy2, done2, taken2;
    logic [1:0] branch_count2, taken_count2;
    logic [16:0] strb, strb2;

    int n_vec = 0;
    int n_err = 0;
    int m_bc = 0;
    int m_tc = 0;
    bit m_taken = 0;
    bit pending = 0;

    localparam int B_PCOUT = 16, B_MARIN = 15, B_INCPC = 14, B_ZIN = 13, B_ZLOW = 12, B_PCIN = 11;
    localparam int B_READ = 10, B_MDATA = 9, B_MDRIN = 8, B_MDROUT = 7, B_IRIN = 6, B_GRA = 5;
    localparam int B_ROUT = 4, B_CONIN = 3, B_YIN = 2, B_COUT = 1, B_ADD = 0;

    always #5 Clock = ~Clock;

    branch_sequencer dut (
        .Clock(Clock), .clear(clear), .start(start), .mem_done(mem_done), .CON(CON),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin),
        .Read(Read), .Mdatain(Mdatain), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Gra(Gra),
        .Rout(Rout), .CONin(CONin), .Yin(Yin), .Cout(Cout), .ADD(ADD),
        .busy(busy), .done(done), .taken(taken),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    branch_sequencer #(.CNT_W(2)) dut2 (
        .Clock(Clock), .clear(clear), .start(start), .mem_done(mem_done), .CON(CON),
        .PCout(PCout2), .MARin(MARin2), .IncPC(IncPC2), .Zin(Zin2), .Zlowout(Zlowout2), .PCin(PCin2),
        .Read(Read2), .Mdatain(Mdatain2), .MDRin(MDRin2), .MDRout(MDRout2), .IRin(IRin2), .Gra(Gra2),
        .Rout(Rout2), .CONin(CONin2), .Yin(Yin2), .Cout(Cout2), .ADD(ADD2),
        .busy(busy2), .done(done2), .taken(taken2),
        .branch_count(branch_count2), .taken_count(taken_count2)
    );

    assign strb  = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Mdatain, MDRin,
                    MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD};
    assign strb2 = {PCout2, MARin2, IncPC2, Zin2, Zlowout2, PCin2, Read2, Mdatain2, MDRin2,
                    MDRout2, IRin2, Gra2, Rout2, CONin2, Yin2, Cout2, ADD2};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // phase 0 = idle, 1..7 = T0..T6
    function automatic logic [16:0] exp_strobes(input int ph, input logic con);
        logic [16:0] s = '0;
        if (ph == 1) begin s[B_PCOUT] = 1; s[B_MARIN] = 1; s[B_INCPC] = 1; s[B_ZIN] = 1; end
        if (ph == 2) begin s[B_ZLOW] = 1; s[B_PCIN] = 1; s[B_READ] = 1; s[B_MDATA] = 1; s[B_MDRIN] = 1; end
        if (ph == 3) begin s[B_MDROUT] = 1; s[B_IRIN] = 1; end
        if (ph == 4) begin s[B_GRA] = 1; s[B_ROUT] = 1; s[B_CONIN] = 1; end
        if (ph == 5) begin s[B_PCOUT] = 1; s[B_YIN] = 1; end
        if (ph == 6) begin s[B_COUT] = 1; s[B_ADD] = 1; s[B_ZIN] = 1; end
        if (ph == 7) begin s[B_ZLOW] = 1; s[B_PCIN] = con; end
        return s;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit eval_cond(input cond_e c, input logic [31:0] v);
        case (c)
            COND_ZR: return v == 0;
            COND_NZ: return v != 0;
            COND_PL: return !v[31];
            default: return v[31];
        endcase
    endfunction

    // check one cycle in the given phase, then advance the model across the edge
    task automatic step(input int ph);
        logic con_now;
        @(negedge Clock);
        con_now = CON;
        chk($sformatf("strobes_p%0d", ph), 32'(strb), 32'(exp_strobes(ph, con_now)));
        chk($sformatf("strobes2_p%0d", ph), 32'(strb2), 32'(exp_strobes(ph, con_now)));
        chk($sformatf("busy_p%0d", ph), 32'(busy), 32'(ph != 0));
        chk($sformatf("done_p%0d", ph), 32'(done), 32'(ph == 7));
        chk("taken", 32'(taken), 32'(m_taken));
        chk("branch_count", 32'(branch_count), 32'(sat(m_bc, 65535)));
        chk("taken_count", 32'(taken_count), 32'(sat(m_tc, 65535)));
        chk("branch_count2", 32'(branch_count2), 32'(sat(m_bc, 3)));
        chk("taken_count2", 32'(taken_count2), 32'(sat(m_tc, 3)));
        @(posedge Clock);
        #1;
        if (!clear) begin
            m_bc = 0; m_tc = 0; m_taken = 0; pending = 0;
        end else if (ph == 7) begin
            m_bc++;
            m_tc += int'(con_now);
            m_taken = con_now;
        end
    endtask

    task automatic run_branch(input bit con, input int waits, input bit b2b, input bit junk);
        if (!pending) begin
            start = 1; CON = 1'($urandom); step(0);
        end
        start = 0; mem_done = 1'($urandom); CON = 1'($urandom);
        step(1);
        mem_done = 0;
        for (int w = 0; w < waits; w++) step(2);
        mem_done = 1; step(2);
        mem_done = 0; step(3);
        start = junk; step(4);
        start = 0; CON = con;
        step(5);
        step(6);
        start = b2b; step(7);
        start = 0;
        pending = b2b;
    endtask

    initial begin
        clear = 0; start = 1; mem_done = 0; CON = 0;
        repeat (2) @(posedge Clock);
        #1;
        step(0);
        clear = 1; start = 0;
        step(0);
        run_branch(1, 0, 0, 0);
        run_branch(0, 0, 0, 0);
        run_branch(1, 3, 0, 0);
        run_branch(0, 0, 1, 1);
        run_branch(1, 1, 0, 0);
        start = 1; step(0);
        start = 0; mem_done = 1; step(1);
        step(2);
        mem_done = 0; step(3);
        step(4);
        clear = 0; step(5);
        clear = 1; step(0);
        repeat (5) run_branch(1, 0, 0, 0);
        chk("sat_branch2", 32'(branch_count2), 32'd3);
        chk("sat_taken2", 32'(taken_count2), 32'd3);
        chk("count16", 32'(branch_count), 32'd5);
        for (int i = 0; i < 30; i++) begin
            cond_e c = cond_e'($urandom_range(0, 3));
            logic [31:0] v = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_branch(eval_cond(c, v), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
        end
        if (pending) run_branch(0, 0, 0, 0);
        step(0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Control-unit slice that sequences a conditional-branch instruction (brzr/brnz/brpl/brmi) through fetch, condition evaluation and target update. It is the consumer side of the CON flip-flop interface: it asserts CONin while the tested register is on the bus, then samples the resulting CON bit to decide whether PCin fires. It also keeps saturating statistics counters for issued and taken branches.

## Interface

Parameters:
- CNT_W, 16, width of the branch_count and taken_count statistics counters.

Ports:
- Clock  in  1  system clock, rising-edge active.
- clear  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request from decode to run a branch sequence.
- mem_done  in  1  memory read data valid; qualifies leaving T1.
- CON  in  1  registered condition result from the CON flip-flop.
- PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Mdatain, MDRin, MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD  out  1 each  datapath control strobes.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in T6.
- taken  out  1  registered; 1 if the last completed branch updated PC.
- branch_count  out  CNT_W  branches completed since reset, saturating.
- taken_count  out  CNT_W  branches taken since reset, saturating.

## Operation

- States: IDLE, T0, T1, T2, T3, T4, T5, T6, encoded in 4 bits.
- Strobes are Moore outputs decoded from the state register; every strobe not listed for a state is 0.
  - IDLE: none.
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, Mdatain, MDRin.
  - T2: MDRout, IRin.
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, ADD, Zin.
  - T6: Zlowout, plus PCin only when CON=1.
- Transitions:
  - IDLE->T0 when start=1.
  - T0->T1.
  - T1 holds while mem_done=0 and moves to T2 when mem_done=1. All T1 strobes stay asserted while it holds.
  - T2->T3->T4->T5->T6 unconditionally.
  - T6->T0 if start=1 (back-to-back, no bubble); otherwise T6->IDLE.
- start in any state other than IDLE or T6 is ignored; it is neither queued nor an error.
- In T6, PCin is driven combinationally from CON. CON is valid from T4 onward, because CONin was asserted in T3.
- At the T6 exit edge:
  - taken is loaded with CON.
  - branch_count increments.
  - taken_count increments if CON=1.
  - Both counters saturate at all-ones and never wrap.
- clear=0 at a rising edge from any state, including mid-sequence and during a T1 wait:
  - state goes to IDLE;
  - taken, branch_count and taken_count go to 0.
  - The interrupted branch is not counted.
  - clear overrides start in the same cycle.
- Reset values: every strobe 0, busy 0, done 0, taken 0, both counters 0.

## Timing

- Minimum sequence length is 7 cycles, T0..T6, with mem_done high in the first T1 cycle. Each cycle mem_done stays low adds 1.
- start sampled at edge N puts the block in T0 during cycle N+1.
- done and the conditional PCin are asserted during the T6 cycle.
- taken and the counters update at the edge that leaves T6, so they are visible in the following cycle.
- Back-to-back: with start high during T6, the next T0 immediately follows T6. The first branch's counter update and the new T0 happen at the same edge.
- busy falls in the cycle after T6 only when no back-to-back start occurs.

## Structure

- Shared package holds:
  - the state encoding constants (IDLE=0, T0..T6 = 1..7);
  - the branch condition codes for IR[20:19]: 00 zero, 01 nonzero, 10 plus, 11 minus. These are for bench checking only; the CON flip-flop evaluates them.
- One natural sub-module: sat_counter, parameterised by CNT_W, with inputs clear, inc and outputs count. It is instantiated twice.
- The FSM and strobe decode stay in the top module, as one sequential block plus one combinational block.

## Test plan

- Reset: hold clear=0 for 2 cycles with start=1. Required: state IDLE, all outputs 0, counters 0.
- Taken branch: start pulse, mem_done=1 at once, CON=1 from T4. Required:
  - T0..T6 over 7 cycles, with the correct strobe set in each state;
  - PCin high in T6;
  - taken=1, branch_count=1 and taken_count=1 afterwards.
- Not-taken branch: same stimulus with CON=0. Required: PCin low in T6, taken=0, branch_count increments, taken_count unchanged.
- Memory wait: mem_done low for 3 cycles in T1. Required: T1 strobes held for 4 cycles, total sequence 10 cycles, done pulse once.
- Back-to-back and ignored start:
  - start high during T6 -> next cycle is T0 with no IDLE, and the counters update.
  - start pulsed during T3 -> no effect.
- Mid-sequence reset and saturation:
  - clear=0 during T4 -> IDLE next cycle, counters 0.
  - With CNT_W=2, run 5 taken branches -> both counters read 3.
